// File: rtl/regfile_rr_arbiter.sv
// Round-robin arbiter/sequencer letting two requesters share one 4-word register file, one command at a time.
// Latency: accept at cycle 0, file access in cycle 1, response pulse in cycle 2, next accept possible in cycle 3.
// Backpressure: ready is offered only in IDLE; a requester holds valid and its command stable until accepted.
module regfile_rr_arbiter #(
    parameter int DW       = 4,
    parameter int AW       = 2,
    parameter bit PRIO_RST = 1'b0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          a_valid,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ready,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_valid,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ready,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          RF_RW,
    output logic [AW-1:0] RF_AD,
    output logic [DW-1:0] RF_DIN,
    input  logic [DW-1:0] RF_DOUT,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          prio;       // requester favoured on a tie: 0=A, 1=B
    logic          owner;      // requester owning the transaction in flight: 0=A, 1=B
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [DW-1:0] rdata_q;
    logic          grant_a;
    logic          grant_b;

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration, next state and all output decode; the file sees a quiet bus outside EXEC.
    always_comb begin
        state_nxt = state;
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        RF_RW     = 1'b0;
        RF_AD     = '0;
        RF_DIN    = '0;
        a_rvalid  = 1'b0;
        b_rvalid  = 1'b0;
        a_rdata   = '0;
        b_rdata   = '0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                // A lone requester always wins; prio only breaks ties. No grant while in reset.
                if (!RST) begin
                    grant_a = a_valid && (!b_valid || !prio);
                    grant_b = b_valid && (!a_valid ||  prio);
                end
                if (grant_a || grant_b) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                busy      = 1'b1;
                RF_RW     = cmd_we;
                RF_AD     = cmd_addr;
                RF_DIN    = cmd_we ? cmd_wdata : '0;
                state_nxt = RESP;
            end
            RESP: begin
                busy      = 1'b1;
                a_rvalid  = !owner;
                b_rvalid  = owner;
                a_rdata   = owner ? '0 : rdata_q;
                b_rdata   = owner ? rdata_q : '0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Command latch on grant, read capture in EXEC, priority hand-over in RESP.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prio      <= PRIO_RST;
            owner     <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            if (grant_a || grant_b) begin
                owner     <= grant_b;
                cmd_we    <= grant_b ? b_we    : a_we;
                cmd_addr  <= grant_b ? b_addr  : a_addr;
                cmd_wdata <= grant_b ? b_wdata : a_wdata;
            end
            if (state == EXEC) begin
                rdata_q <= cmd_we ? '0 : RF_DOUT;
            end
            if (state == RESP) begin
                prio <= ~owner;
            end
        end
    end

endmodule

// File: tb/tb_regfile_rr_arbiter.sv
// Bench for regfile_rr_arbiter: directed transaction table, hand-written corner sequences, then random traffic.
// A behavioural 4x4 register file is attached to the RF_* bus so reads return real stored data.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_regfile_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, a_we, b_valid, b_we;
    logic [1:0] a_addr, b_addr;
    logic [3:0] a_wdata, b_wdata;
    logic       a_ready, a_rvalid, b_ready, b_rvalid;
    logic [3:0] a_rdata, b_rdata;
    logic       rf_rw;
    logic [1:0] rf_ad;
    logic [3:0] rf_din, rf_dout;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_rr_arbiter #(.DW(4), .AW(2), .PRIO_RST(1'b0)) dut (
        .CLK(clk), .RST(rst),
        .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .RF_RW(rf_rw), .RF_AD(rf_ad), .RF_DIN(rf_din), .RF_DOUT(rf_dout),
        .busy(busy)
    );

    // Register file model: synchronous write and reset, combinational read, 0 while writing.
    logic [3:0] rf_mem [4];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) rf_mem[i] <= 4'h0;
        end else if (rf_rw) begin
            rf_mem[rf_ad] <= rf_din;
        end
    end
    assign rf_dout = rf_rw ? 4'h0 : rf_mem[rf_ad];

    task automatic chk(input string nm, input int act, input int want);
        n_chk++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, want, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One directed transaction slot: requester commands plus expected winner (0 none, 1 A, 2 B) and read data.
    typedef struct {
        logic       av, aw;
        logic [1:0] aa;
        logic [3:0] ad;
        logic       bv, bw;
        logic [1:0] ba;
        logic [3:0] bd;
        logic [1:0] win;
        logic [3:0] rd;
    } vec_t;

    function automatic vec_t mk(input logic av, input logic aw, input logic [1:0] aa, input logic [3:0] ad,
                                input logic bv, input logic bw, input logic [1:0] ba, input logic [3:0] bd,
                                input logic [1:0] win, input logic [3:0] rd);
        vec_t v;
        v.av = av; v.aw = aw; v.aa = aa; v.ad = ad;
        v.bv = bv; v.bw = bw; v.ba = ba; v.bd = bd;
        v.win = win; v.rd = rd;
        return v;
    endfunction

    // Random-phase reference model state (transaction level).
    int         cyc, free_at, resp_cyc;
    logic       m_prio, resp_who, win_b, exp_ra, exp_rb, rva, rvb;
    logic [3:0] resp_dat, c_wd;
    logic [1:0] c_ad;
    logic       c_we;
    logic [3:0] exp_mem [4];
    logic       pa, pb, qa_we, qb_we;
    logic [1:0] qa_ad, qb_ad;
    logic [3:0] qa_wd, qb_wd;

    initial begin
        vec_t tbl [14];
        vec_t r;
        logic w_we;
        logic [1:0] w_ad;
        logic [3:0] w_wd;

        rst = 1'b1;
        a_valid = 1'b1; a_we = 1'b1; a_addr = 2'd1; a_wdata = 4'hF;
        b_valid = 1'b0; b_we = 1'b0; b_addr = 2'd0; b_wdata = 4'h0;

        // Reset held two cycles with A valid: no grant, everything quiet.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_a_ready", int'(a_ready), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_rf_rw", int'(rf_rw), 0);
            chk("rst_rf_ad_din", int'({rf_ad, rf_din}), 0);
            chk("rst_rvalid", int'({a_rvalid, b_rvalid}), 0);
            chk("rst_rdata", int'({a_rdata, b_rdata}), 0);
            next_cycle();
        end
        rst = 1'b0;
        a_valid = 1'b0;
        @(negedge clk);
        chk("idle_rf_rw", int'(rf_rw), 0);
        chk("idle_busy", int'(busy), 0);
        next_cycle();

        // Directed slots; a losing requester keeps its command into the following slot.
        tbl[0]  = mk(1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 2'd0, 4'h0);
        tbl[1]  = mk(1'b1, 1'b1, 2'd2, 4'hA, 1'b0, 1'b0, 2'd0, 4'h0, 2'd1, 4'h0);
        tbl[2]  = mk(1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 2'd2, 4'h0, 2'd2, 4'hA);
        tbl[3]  = mk(1'b1, 1'b1, 2'd1, 4'h5, 1'b1, 1'b1, 2'd3, 4'hC, 2'd1, 4'h0);
        tbl[4]  = mk(1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 1'b1, 2'd3, 4'hC, 2'd2, 4'h0);
        tbl[5]  = mk(1'b1, 1'b0, 2'd1, 4'h0, 1'b1, 1'b0, 2'd3, 4'h0, 2'd1, 4'h5);
        tbl[6]  = mk(1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 2'd3, 4'h0, 2'd2, 4'hC);
        tbl[7]  = mk(1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 2'd2, 4'h0, 2'd1, 4'h0);
        tbl[8]  = mk(1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 2'd2, 4'h0, 2'd2, 4'hA);
        tbl[9]  = mk(1'b1, 1'b0, 2'd3, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 2'd1, 4'hC);
        tbl[10] = mk(1'b1, 1'b1, 2'd0, 4'h7, 1'b0, 1'b0, 2'd0, 4'h0, 2'd1, 4'h0);
        tbl[11] = mk(1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 1'b1, 2'd1, 4'h9, 2'd2, 4'h0);
        tbl[12] = mk(1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 2'd1, 4'h7);
        tbl[13] = mk(1'b1, 1'b0, 2'd1, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 2'd1, 4'h9);

        for (int i = 0; i < 14; i++) begin
            r = tbl[i];
            a_valid = r.av; a_we = r.aw; a_addr = r.aa; a_wdata = r.ad;
            b_valid = r.bv; b_we = r.bw; b_addr = r.ba; b_wdata = r.bd;
            @(negedge clk);
            chk("tbl_a_ready", int'(a_ready), int'(r.win == 2'd1));
            chk("tbl_b_ready", int'(b_ready), int'(r.win == 2'd2));
            chk("tbl_busy_idle", int'(busy), 0);
            next_cycle();
            if (r.win != 2'd0) begin
                w_we = (r.win == 2'd1) ? r.aw : r.bw;
                w_ad = (r.win == 2'd1) ? r.aa : r.ba;
                w_wd = (r.win == 2'd1) ? r.ad : r.bd;
                if (r.win == 2'd1) a_valid = 1'b0;
                else               b_valid = 1'b0;
                @(negedge clk);
                chk("tbl_exec_rf_rw", int'(rf_rw), int'(w_we));
                chk("tbl_exec_rf_ad", int'(rf_ad), int'(w_ad));
                chk("tbl_exec_rf_din", int'(rf_din), w_we ? int'(w_wd) : 0);
                chk("tbl_exec_busy", int'(busy), 1);
                chk("tbl_exec_ready", int'({a_ready, b_ready}), 0);
                next_cycle();
                @(negedge clk);
                chk("tbl_resp_a_rvalid", int'(a_rvalid), int'(r.win == 2'd1));
                chk("tbl_resp_b_rvalid", int'(b_rvalid), int'(r.win == 2'd2));
                chk("tbl_resp_a_rdata", int'(a_rdata), (r.win == 2'd1) ? int'(r.rd) : 0);
                chk("tbl_resp_b_rdata", int'(b_rdata), (r.win == 2'd2) ? int'(r.rd) : 0);
                chk("tbl_resp_rf_rw", int'(rf_rw), 0);
                chk("tbl_resp_ready", int'({a_ready, b_ready}), 0);
                next_cycle();
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;

        // Both requesters valid for 12 cycles from reset: grants A,B,A,B at cycles 0,3,6,9.
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        a_valid = 1'b1; a_we = 1'b0; a_addr = 2'd0;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 2'd1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("alt_a_ready", int'(a_ready), int'((c % 3 == 0) && ((c / 3) % 2 == 0)));
            chk("alt_b_ready", int'(b_ready), int'((c % 3 == 0) && ((c / 3) % 2 == 1)));
            next_cycle();
        end
        a_valid = 1'b0; b_valid = 1'b0;

        // B raises valid during A's EXEC: held off until the next IDLE, A's response unaffected.
        a_valid = 1'b1; a_we = 1'b1; a_addr = 2'd1; a_wdata = 4'h6;
        @(negedge clk);
        chk("late_a_ready_c0", int'(a_ready), 1);
        next_cycle();
        a_valid = 1'b0;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 2'd1;
        @(negedge clk);
        chk("late_b_ready_c1", int'(b_ready), 0);
        next_cycle();
        @(negedge clk);
        chk("late_b_ready_c2", int'(b_ready), 0);
        chk("late_a_rvalid_c2", int'(a_rvalid), 1);
        chk("late_a_rdata_c2", int'(a_rdata), 0);
        chk("late_b_rvalid_c2", int'(b_rvalid), 0);
        next_cycle();
        @(negedge clk);
        chk("late_b_ready_c3", int'(b_ready), 1);
        next_cycle();
        b_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("late_b_rvalid_c5", int'(b_rvalid), 1);
        chk("late_b_rdata_c5", int'(b_rdata), 6);
        chk("late_a_rvalid_c5", int'(a_rvalid), 0);
        next_cycle();

        // A read moves priority to B; then reset hits the next A read in EXEC.
        a_valid = 1'b1; a_we = 1'b0; a_addr = 2'd1;
        @(negedge clk);
        chk("pre_rst_a_ready", int'(a_ready), 1);
        next_cycle();
        a_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("pre_rst_a_rdata", int'(a_rdata), 6);
        next_cycle();
        a_valid = 1'b1;
        @(negedge clk);
        chk("mid_a_ready", int'(a_ready), 1);
        next_cycle();
        a_valid = 1'b0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("mid_rst_a_rvalid", int'(a_rvalid), 0);
            chk("mid_rst_busy", int'(busy), 0);
            chk("mid_rst_rf_rw", int'(rf_rw), 0);
            next_cycle();
        end
        a_valid = 1'b1; b_valid = 1'b1;
        @(negedge clk);
        chk("mid_rst_prio_a", int'(a_ready), 1);
        chk("mid_rst_prio_b", int'(b_ready), 0);
        next_cycle();
        a_valid = 1'b0; b_valid = 1'b0;

        // Random traffic against a transaction-level model: one service per 3 cycles, favour flips to the other side.
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) exp_mem[i] = 4'h0;
        cyc = 0; free_at = 0; resp_cyc = -10; m_prio = 1'b0;
        resp_who = 1'b0; resp_dat = 4'h0;
        pa = 1'b0; pb = 1'b0;
        qa_we = 1'b0; qa_ad = 2'd0; qa_wd = 4'h0;
        qb_we = 1'b0; qb_ad = 2'd0; qb_wd = 4'h0;
        for (int n = 0; n < 400; n++) begin
            if (!pa && $urandom_range(0, 99) < 45) begin
                pa = 1'b1; qa_we = 1'($urandom_range(0, 1));
                qa_ad = 2'($urandom_range(0, 3)); qa_wd = 4'($urandom_range(0, 15));
            end
            if (!pb && $urandom_range(0, 99) < 45) begin
                pb = 1'b1; qb_we = 1'($urandom_range(0, 1));
                qb_ad = 2'($urandom_range(0, 3)); qb_wd = 4'($urandom_range(0, 15));
            end
            a_valid = pa; a_we = qa_we; a_addr = qa_ad; a_wdata = qa_wd;
            b_valid = pb; b_we = qb_we; b_addr = qb_ad; b_wdata = qb_wd;
            @(negedge clk);
            exp_ra = 1'b0; exp_rb = 1'b0;
            if (cyc >= free_at && (pa || pb)) begin
                win_b  = pb && (!pa || m_prio);
                exp_ra = !win_b;
                exp_rb = win_b;
                c_we = win_b ? qb_we : qa_we;
                c_ad = win_b ? qb_ad : qa_ad;
                c_wd = win_b ? qb_wd : qa_wd;
                resp_cyc = cyc + 2;
                resp_who = win_b;
                resp_dat = c_we ? 4'h0 : exp_mem[c_ad];
                if (c_we) exp_mem[c_ad] = c_wd;
                m_prio  = !win_b;
                free_at = cyc + 3;
            end
            rva = (cyc == resp_cyc) && !resp_who;
            rvb = (cyc == resp_cyc) &&  resp_who;
            chk("rnd_a_ready", int'(a_ready), int'(exp_ra));
            chk("rnd_b_ready", int'(b_ready), int'(exp_rb));
            chk("rnd_a_rvalid", int'(a_rvalid), int'(rva));
            chk("rnd_b_rvalid", int'(b_rvalid), int'(rvb));
            chk("rnd_a_rdata", int'(a_rdata), rva ? int'(resp_dat) : 0);
            chk("rnd_b_rdata", int'(b_rdata), rvb ? int'(resp_dat) : 0);
            chk("rnd_busy", int'(busy), int'(cyc < free_at && cyc + 3 > free_at));
            next_cycle();
            if (exp_ra) pa = 1'b0;
            if (exp_rb) pb = 1'b0;
            cyc++;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no summary, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
